seu_inject_sequencer: RTL and testbench

SEU_INJECT_SEQUENCER -- requirements
Module: seu_inject_sequencer

---
 rtl/seu_inject_if.sv | 30 +++
 rtl/seu_inject_sequencer.sv | 113 +++++++++++
 tb/tb_seu_inject_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seu_inject_if.sv
// Command and status bundle between an SEU campaign controller and the injection sequencer.
interface seu_inject_if #(
  parameter int N_TARGETS = 16,
  parameter int IDX_W     = 4,
  parameter int DLY_W     = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [IDX_W-1:0]     cmd_target;
  logic                 cmd_random;
  logic [DLY_W-1:0]     cmd_delay;
  logic [7:0]           cmd_count;
  logic                 abort;
  logic [N_TARGETS-1:0] seu;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [15:0]          inj_count;
  logic [IDX_W-1:0]     last_target;

  modport master (
    output cmd_valid, cmd_target, cmd_random, cmd_delay, cmd_count, abort,
    input  cmd_ready, seu, busy, done, err, inj_count, last_target
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_random, cmd_delay, cmd_count, abort,
    output cmd_ready, seu, busy, done, err, inj_count, last_target
  );
endinterface

// File: rtl/seu_inject_sequencer.sv
// Emits bursts of one-hot SEU strobes into a flip-flop array, fixed or LFSR-chosen targets.
//   state | meaning
//   IDLE  | ready for a command
//   WAIT  | counting down the inter-injection delay
//   FIRE  | one-cycle strobe on the selected target
//   DONE  | one-cycle completion pulse
module seu_inject_sequencer #(
  parameter int N_TARGETS = 16,
  parameter int IDX_W     = 4,
  parameter int DLY_W     = 16
) (
  input  logic         CLK,
  input  logic         RN,
  seu_inject_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, FIRE, DONE} state_t;

  state_t           state, state_nx;
  logic [DLY_W-1:0] dly_cnt, dly_cfg;
  logic [7:0]       remain;
  logic             rnd_cfg;
  logic [IDX_W-1:0] tgt_cfg, tgt, last_tgt;
  logic [IDX_W-1:0] lfsr_idx, rnd_tgt, fire_tgt;
  logic [15:0]      lfsr, inj_cnt;
  logic             err_q, accept, bad_tgt;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign bad_tgt = !bus.cmd_random && (32'(bus.cmd_target) >= N_TARGETS);

  // Out-of-range LFSR indices fold back by one N_TARGETS, always landing in range.
  assign lfsr_idx = lfsr[IDX_W-1:0];
  assign rnd_tgt  = (32'(lfsr_idx) >= N_TARGETS) ? lfsr_idx - IDX_W'(N_TARGETS) : lfsr_idx;
  assign fire_tgt = rnd_cfg ? rnd_tgt : tgt_cfg;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && !bad_tgt)
          state_nx = (bus.cmd_count == 8'd0) ? DONE : WAIT;
      end
      WAIT: begin
        if (bus.abort)
          state_nx = IDLE;
        else if (dly_cnt == '0)
          state_nx = FIRE;
      end
      FIRE: begin
        if (bus.abort)
          state_nx = IDLE;
        else if (remain == 8'd1)
          state_nx = DONE;
        else
          state_nx = WAIT;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state    <= IDLE;
      lfsr     <= 16'hACE1;
      err_q    <= 1'b0;
      inj_cnt  <= 16'd0;
      last_tgt <= '0;
      dly_cnt  <= '0;
      dly_cfg  <= '0;
      remain   <= 8'd0;
      rnd_cfg  <= 1'b0;
      tgt_cfg  <= '0;
      tgt      <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= {^(lfsr & 16'h002D), lfsr[15:1]};
      err_q <= accept && bad_tgt;
      if (accept) begin
        dly_cfg <= bus.cmd_delay;
        dly_cnt <= bus.cmd_delay;
        remain  <= bus.cmd_count;
        rnd_cfg <= bus.cmd_random;
        tgt_cfg <= bus.cmd_target;
      end
      case (state)
        WAIT: begin
          if (dly_cnt != '0)
            dly_cnt <= dly_cnt - DLY_W'(1);
          if (state_nx == FIRE)
            tgt <= fire_tgt;
        end
        FIRE: begin
          remain   <= remain - 8'd1;
          dly_cnt  <= dly_cfg;
          last_tgt <= tgt;
          if (inj_cnt != 16'hFFFF)
            inj_cnt <= inj_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.seu         = (state == FIRE) ? (N_TARGETS'(1) << tgt) : '0;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err         = err_q;
  assign bus.inj_count   = inj_cnt;
  assign bus.last_target = last_tgt;

endmodule

// File: tb/tb_seu_inject_sequencer.sv
// Randomized scoreboard bench for seu_inject_sequencer with a 12-target array.
module tb_seu_inject_sequencer;
  localparam int NT = 12;
  localparam int IW = 4;
  localparam int DW = 16;

  typedef struct {
    int            cyc;
    logic [NT-1:0] val;
  } seu_exp_t;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_inj = 0;
  logic [IW-1:0] exp_last = '0;
  logic [15:0]   lfsr_m = 16'h0;

  seu_exp_t seu_q[$];
  int       done_q[$];
  int       err_q[$];

  seu_inject_if #(.N_TARGETS(NT), .IDX_W(IW), .DLY_W(DW)) bus ();

  seu_inject_sequencer #(.N_TARGETS(NT), .IDX_W(IW), .DLY_W(DW)) dut (
    .CLK(CLK),
    .RN (RN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference LFSR: feedback is the parity of taps 16,14,13,11 (bits 0,2,3,5).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & 16'b0000_0000_0010_1101), s[15:1]};
  endfunction

  always @(posedge CLK) lfsr_m <= (!RN) ? 16'hACE1 : lfsr_step(lfsr_m);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe, done and err the DUT shows must match the head of its queue.
  always @(negedge CLK) begin
    if (RN === 1'b1) begin
      if (bus.seu !== '0) begin
        if (seu_q.size() == 0) begin
          check("seu_unexpected", 32'(bus.seu), 32'h0);
        end else begin
          seu_exp_t e;
          e = seu_q.pop_front();
          check("seu_value", 32'(bus.seu), 32'(e.val));
          check("seu_cycle", cyc, e.cyc);
        end
      end
      if (bus.done !== 1'b0) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(bus.done), 32'h0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
      if (bus.err !== 1'b0) begin
        if (err_q.size() == 0) check("err_unexpected", 32'(bus.err), 32'h0);
        else check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic issue(input int tgt, input bit rnd, input int dly, input int cnt, output int acc);
    int budget;
    int t;
    logic [15:0] s, s2;
    budget = 50;
    t = 0;
    @(negedge CLK);
    while (bus.cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (budget == 0) check("ready_timeout", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_target = IW'(tgt);
    bus.cmd_random = rnd;
    bus.cmd_delay  = DW'(dly);
    bus.cmd_count  = 8'(cnt);
    bus.cmd_valid  = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    s = lfsr_m;
    bus.cmd_valid = 1'b0;
    if (!rnd && tgt >= NT) begin
      err_q.push_back(acc);
    end else if (cnt == 0) begin
      done_q.push_back(acc);
    end else begin
      for (int k = 0; k < cnt; k++) begin
        seu_exp_t e;
        s2 = s;
        repeat (dly + k * (dly + 2)) s2 = lfsr_step(s2);
        t = rnd ? int'(s2[IW-1:0]) : tgt;
        if (t >= NT) t = t - NT;
        e.cyc = acc + dly + 1 + k * (dly + 2);
        e.val = NT'(1) << t;
        seu_q.push_back(e);
      end
      done_q.push_back(acc + dly + 1 + (cnt - 1) * (dly + 2) + 1);
      exp_inj += cnt;
      exp_last = IW'(t);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((seu_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) && budget > 0) begin
      @(negedge CLK);
      #2;
      if (seu_q.size() != 0 || done_q.size() != 0) check("busy_in_burst", 32'(bus.busy), 32'h1);
      budget--;
    end
    if (budget == 0) check("drain_timeout", seu_q.size() + done_q.size() + err_q.size(), 0);
    @(negedge CLK);
    #2;
    check("idle_ready", 32'(bus.cmd_ready), 32'h1);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("inj_count", 32'(bus.inj_count), exp_inj);
    check("last_target", 32'(bus.last_target), 32'(exp_last));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_random = 1'b0;
    bus.cmd_delay  = '0;
    bus.cmd_count  = 8'd0;
    bus.abort      = 1'b0;
    idle(4);
    RN = 1'b1;
    #1;
    check("rst_seu", 32'(bus.seu), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_inj", 32'(bus.inj_count), 32'h0);
    check("rst_last", 32'(bus.last_target), 32'h0);
    check("rst_ready", 32'(bus.cmd_ready), 32'h1);
    idle(2);

    // single fixed injection
    issue(5, 1'b0, 0, 1, acc);
    drain();

    // three spaced pulses; a bogus command held during the burst must be ignored
    issue(3, 1'b0, 2, 3, acc);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 4'd9;
    bus.cmd_count  = 8'd1;
    bus.cmd_delay  = '0;
    while (cyc < acc + 9) @(negedge CLK);
    bus.cmd_valid = 1'b0;
    drain();

    // random burst from the LFSR
    issue(0, 1'b1, 0, 20, acc);
    drain();

    // out-of-range fixed target, then an empty burst
    issue(15, 1'b0, 5, 3, acc);
    @(negedge CLK);
    #2;
    check("err_busy", 32'(bus.busy), 32'h0);
    drain();
    issue(4, 1'b0, 7, 0, acc);
    drain();

    // abort during the second WAIT
    issue(5, 1'b0, 10, 5, acc);
    while (seu_q.size() > 1) void'(seu_q.pop_back());
    done_q.delete();
    exp_inj -= 4;
    while (cyc < acc + 14) @(negedge CLK);
    bus.abort = 1'b1;
    @(posedge CLK);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_ready", 32'(bus.cmd_ready), 32'h1);
    idle(15);
    drain();

    // abort coinciding with a strobe: strobe still counted
    issue(7, 1'b0, 2, 3, acc);
    while (seu_q.size() > 2) void'(seu_q.pop_back());
    done_q.delete();
    exp_inj -= 1;
    while (cyc < acc + 7) @(negedge CLK);
    bus.abort = 1'b1;
    @(posedge CLK);
    #1;
    bus.abort = 1'b0;
    check("abort_fire_busy", 32'(bus.busy), 32'h0);
    idle(10);
    drain();

    // random traffic with idle-time abort pulses
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort = 1'b0;
      end
      idle($urandom_range(0, 3));
      issue($urandom_range(0, 15), ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            $urandom_range(0, 4), acc);
      drain();
    end

    // reset during FIRE discards the burst
    issue(2, 1'b0, 3, 4, acc);
    while (cyc < acc + 4) @(negedge CLK);
    #1;
    RN = 1'b0;
    seu_q.delete();
    done_q.delete();
    exp_inj  = 0;
    exp_last = '0;
    @(posedge CLK);
    #1;
    check("rstfire_seu", 32'(bus.seu), 32'h0);
    check("rstfire_inj", 32'(bus.inj_count), 32'h0);
    check("rstfire_last", 32'(bus.last_target), 32'h0);
    check("rstfire_busy", 32'(bus.busy), 32'h0);
    @(negedge CLK);
    RN = 1'b1;
    idle(30);
    check("post_rst_inj", 32'(bus.inj_count), 32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'h0);

    // sequencer still works after reset, with a fresh LFSR
    issue(0, 1'b1, 1, 4, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
